// File: rtl/register_file_mp.sv
// register_file_mp: multi-port integer register file with write-to-read bypass and busy scoreboard
module register_file_mp #(
    parameter int XLEN     = 32,
    parameter int NREGS    = 32,
    parameter int NRD      = 2,
    parameter int NWR      = 2,
    parameter bit BYPASS   = 1'b1,
    parameter bit ZERO_REG = 1'b1,
    localparam int AW      = $clog2(NREGS)
) (
    input  logic                clk,
    input  logic                rst_h,
    input  logic [NRD*AW-1:0]   rd_addr,
    output logic [NRD*XLEN-1:0] rd_data,
    output logic [NRD-1:0]      rd_busy,
    input  logic [NWR-1:0]      wr_en,
    input  logic [NWR*AW-1:0]   wr_addr,
    input  logic [NWR*XLEN-1:0] wr_data,
    input  logic                alloc_en,
    input  logic [AW-1:0]       alloc_addr,
    output logic [NREGS-1:0]    busy_vec
);
    logic [XLEN-1:0]  regs_q [NREGS];
    logic [XLEN-1:0]  regs_d [NREGS];
    logic [NREGS-1:0] busy_q, busy_d;

    // A writable register: in range and not the hardwired zero register
    function automatic logic ok(input logic [AW-1:0] a);
        return (int'(a) < NREGS) && !(ZERO_REG && a == '0);
    endfunction

    always_comb begin
        regs_d = regs_q;
        busy_d = busy_q;
        for (int p = 0; p < NWR; p++) begin
            if (wr_en[p] && ok(wr_addr[p*AW +: AW])) begin
                regs_d[wr_addr[p*AW +: AW]] = wr_data[p*XLEN +: XLEN];
                busy_d[wr_addr[p*AW +: AW]] = 1'b0;
            end
        end
        // Alloc applied last: a newly issued producer owns the register
        if (alloc_en && ok(alloc_addr))
            busy_d[alloc_addr] = 1'b1;
    end

    always_ff @(posedge clk or posedge rst_h) begin
        if (rst_h) begin
            for (int r = 0; r < NREGS; r++)
                regs_q[r] <= '0;
            busy_q <= '0;
        end else begin
            regs_q <= regs_d;
            busy_q <= busy_d;
        end
    end

    always_comb begin
        rd_data = '0;
        rd_busy = '0;
        for (int i = 0; i < NRD; i++) begin
            if (int'(rd_addr[i*AW +: AW]) < NREGS) begin
                rd_data[i*XLEN +: XLEN] = regs_q[rd_addr[i*AW +: AW]];
                rd_busy[i]              = busy_q[rd_addr[i*AW +: AW]];
            end
            // Ascending loop leaves the highest-index matching port in place
            for (int p = 0; p < NWR; p++) begin
                if (BYPASS && !rst_h && wr_en[p] && ok(wr_addr[p*AW +: AW]) &&
                    wr_addr[p*AW +: AW] == rd_addr[i*AW +: AW]) begin
                    rd_data[i*XLEN +: XLEN] = wr_data[p*XLEN +: XLEN];
                    rd_busy[i]              = 1'b0;
                end
            end
        end
    end

    assign busy_vec = busy_q;
endmodule

// File: tb/tb_register_file_mp.sv
// tb_register_file_mp: directed checks of the register file in bypass, no-bypass and 24/3/3 configurations
module tb_register_file_mp;
    logic clk = 1'b0;
    logic rst_h = 1'b1;
    always #5 clk = ~clk;

    logic [9:0]  a_rd_addr, b_rd_addr, a_wr_addr, b_wr_addr;
    logic [63:0] a_rd_data, b_rd_data, a_wr_data, b_wr_data;
    logic [1:0]  a_rd_busy, b_rd_busy, a_wr_en, b_wr_en;
    logic        a_alloc_en, b_alloc_en, c_alloc_en;
    logic [4:0]  a_alloc_addr, b_alloc_addr, c_alloc_addr;
    logic [31:0] a_busy_vec, b_busy_vec;
    logic [14:0] c_rd_addr, c_wr_addr;
    logic [95:0] c_rd_data, c_wr_data;
    logic [2:0]  c_rd_busy, c_wr_en;
    logic [23:0] c_busy_vec;

    register_file_mp dut_a (
        .clk(clk), .rst_h(rst_h), .rd_addr(a_rd_addr), .rd_data(a_rd_data), .rd_busy(a_rd_busy),
        .wr_en(a_wr_en), .wr_addr(a_wr_addr), .wr_data(a_wr_data),
        .alloc_en(a_alloc_en), .alloc_addr(a_alloc_addr), .busy_vec(a_busy_vec));

    register_file_mp #(.BYPASS(1'b0)) dut_b (
        .clk(clk), .rst_h(rst_h), .rd_addr(b_rd_addr), .rd_data(b_rd_data), .rd_busy(b_rd_busy),
        .wr_en(b_wr_en), .wr_addr(b_wr_addr), .wr_data(b_wr_data),
        .alloc_en(b_alloc_en), .alloc_addr(b_alloc_addr), .busy_vec(b_busy_vec));

    register_file_mp #(.NREGS(24), .NRD(3), .NWR(3)) dut_c (
        .clk(clk), .rst_h(rst_h), .rd_addr(c_rd_addr), .rd_data(c_rd_data), .rd_busy(c_rd_busy),
        .wr_en(c_wr_en), .wr_addr(c_wr_addr), .wr_data(c_wr_data),
        .alloc_en(c_alloc_en), .alloc_addr(c_alloc_addr), .busy_vec(c_busy_vec));

    int n_chk = 0;
    int n_fail = 0;

    task automatic check(input string tag, input logic [95:0] act, input logic [95:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        {a_rd_addr, b_rd_addr, a_wr_addr, b_wr_addr, a_wr_data, b_wr_data} = '0;
        {a_wr_en, b_wr_en, a_alloc_en, b_alloc_en, c_alloc_en} = '0;
        {a_alloc_addr, b_alloc_addr, c_alloc_addr} = '0;
        {c_rd_addr, c_wr_addr, c_wr_data, c_wr_en} = '0;
        repeat (2) tick;
        for (int a = 0; a < 32; a++) begin
            a_rd_addr = {2{a[4:0]}};
            #1;
            check("rst_rd0", a_rd_data[31:0], 0);
            check("rst_rd1", a_rd_data[63:32], 0);
        end
        check("rst_rd_busy", a_rd_busy, 0);
        check("rst_busy_vec", a_busy_vec, 0);
        rst_h = 1'b0;
        tick;

        // Write x5, then reset mid-stream
        a_wr_en = 2'b01; a_wr_addr = {5'd0, 5'd5}; a_wr_data = {32'h0, 32'hDEADBEEF};
        tick;
        a_wr_en = 2'b00; a_rd_addr = {5'd0, 5'd5};
        #1 check("x5_written", a_rd_data[31:0], 32'hDEADBEEF);
        rst_h = 1'b1;
        #1 check("x5_async_rst", a_rd_data[31:0], 0);
        tick;
        rst_h = 1'b0;
        tick;

        // Same-cycle write/read: bypass vs no bypass
        a_wr_en = 2'b01; a_wr_addr = {5'd0, 5'd7}; a_wr_data = {32'h0, 32'h12345678}; a_rd_addr = {5'd0, 5'd7};
        b_wr_en = 2'b01; b_wr_addr = {5'd0, 5'd7}; b_wr_data = {32'h0, 32'h12345678}; b_rd_addr = {5'd0, 5'd7};
        #1;
        check("bypass_same_cycle", a_rd_data[31:0], 32'h12345678);
        check("nobypass_same_cycle", b_rd_data[31:0], 0);
        tick;
        a_wr_en = 2'b00; b_wr_en = 2'b00;
        #1;
        check("bypass_next_cycle", a_rd_data[31:0], 32'h12345678);
        check("nobypass_next_cycle", b_rd_data[31:0], 32'h12345678);

        // Write conflict on x9, and writes to x0
        a_wr_en = 2'b11; a_wr_addr = {5'd9, 5'd9}; a_wr_data = {32'h0000BBBB, 32'hAAAA0000}; a_rd_addr = {5'd9, 5'd9};
        #1 check("conflict_bypass", a_rd_data, {32'h0000BBBB, 32'h0000BBBB});
        tick;
        a_wr_en = 2'b00;
        #1 check("conflict_x9", a_rd_data[63:32], 32'h0000BBBB);
        a_wr_en = 2'b01; a_wr_addr = {5'd0, 5'd0}; a_wr_data = {32'h0, 32'hFFFFFFFF}; a_rd_addr = {5'd9, 5'd0};
        #1 check("x0_bypass", a_rd_data[31:0], 0);
        tick;
        a_wr_en = 2'b00;
        #1 check("x0_after", a_rd_data[31:0], 0);

        // Scoreboard: alloc x3, then writeback clears it
        a_alloc_en = 1'b1; a_alloc_addr = 5'd3; a_rd_addr = {5'd3, 5'd3};
        #1 check("alloc_not_same_cycle", a_rd_busy, 2'b00);
        tick;
        a_alloc_en = 1'b0;
        #1;
        check("alloc_busy_vec", a_busy_vec, 32'h0000_0008);
        check("alloc_rd_busy", a_rd_busy, 2'b11);
        a_wr_en = 2'b01; a_wr_addr = {5'd0, 5'd3}; a_wr_data = {32'h0, 32'h55};
        #1;
        check("wb_rd_busy_bypass", a_rd_busy, 2'b00);
        check("wb_rd_data_bypass", a_rd_data, {32'h55, 32'h55});
        tick;
        a_wr_en = 2'b00;
        #1;
        check("wb_busy_vec", a_busy_vec, 0);
        check("wb_rd_busy", a_rd_busy, 2'b00);

        // Alloc and writeback on x4 in one cycle: alloc wins
        a_alloc_en = 1'b1; a_alloc_addr = 5'd4; a_wr_en = 2'b01; a_wr_addr = {5'd0, 5'd4}; a_wr_data = {32'h0, 32'h77};
        tick;
        a_alloc_en = 1'b0; a_wr_en = 2'b00; a_rd_addr = {5'd3, 5'd4};
        #1;
        check("alloc_wb_data", a_rd_data[31:0], 32'h77);
        check("alloc_wb_busy_vec", a_busy_vec, 32'h0000_0010);
        check("alloc_wb_rd_busy", a_rd_busy, 2'b01);
        a_alloc_en = 1'b1; a_alloc_addr = 5'd0;
        tick;
        a_alloc_en = 1'b0;
        #1 check("alloc_x0_ignored", a_busy_vec, 32'h0000_0010);

        // 24-register, 3R/3W configuration
        c_wr_en = 3'b001; c_wr_addr = {10'd0, 5'd25}; c_wr_data = {64'h0, 32'h1}; c_rd_addr = {5'd9, 5'd1, 5'd25};
        #1 check("c_invalid_bypass", c_rd_data[31:0], 0);
        tick;
        c_wr_en = 3'b000;
        #1;
        check("c_invalid_reads", c_rd_data, 0);
        check("c_invalid_busy", c_busy_vec, 0);
        c_alloc_en = 1'b1; c_alloc_addr = 5'd25;
        tick;
        c_alloc_en = 1'b0;
        #1 check("c_invalid_alloc", c_busy_vec, 0);
        c_wr_en = 3'b111; c_wr_addr = {3{5'd23}}; c_wr_data = {32'h33333333, 32'h22222222, 32'h11111111};
        c_rd_addr = {3{5'd23}};
        #1 check("c_prio_bypass", c_rd_data, {3{32'h33333333}});
        tick;
        c_wr_en = 3'b000;
        #1;
        check("c_prio_reads", c_rd_data, {3{32'h33333333}});
        check("c_rd_busy", c_rd_busy, 3'b000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/register_file_mp.md
Name: register_file_mp

Overview:
Parametrised multi-port integer register file for the RISC-V decode/writeback path. It supports NRD combinational read ports and NWR synchronous write ports. It has optional same-cycle write-to-read bypass and a per-register busy scoreboard that decode uses to detect RAW hazards. All writes occur on the rising clock edge.

Parameters:
XLEN, 32, data width of each register
NREGS, 32, number of architectural registers (2..64)
NRD, 2, number of read ports (1..4)
NWR, 2, number of write ports (1..3); a higher index has higher priority
BYPASS, 1, 1 = a same-cycle write is forwarded to reads and to rd_busy
ZERO_REG, 1, 1 = register 0 is hardwired to zero and is never busy
AW (localparam), $clog2(NREGS), register address width

Ports:
clk  in  1  clock, rising edge
rst_h  in  1  reset
rd_addr  in  NRD*AW  read addresses; port i uses slice [i*AW +: AW]
rd_data  out  NRD*XLEN  read data, combinational
rd_busy  out  NRD  scoreboard busy flag for each read address, combinational
wr_en  in  NWR  write enable per port
wr_addr  in  NWR*AW  write addresses
wr_data  in  NWR*XLEN  write data
alloc_en  in  1  marks alloc_addr busy (an instruction with this destination has issued)
alloc_addr  in  AW  destination register being allocated
busy_vec  out  NREGS  registered scoreboard state

Behaviour:
- Reset (rst_h): asynchronous, active-high. Clears all registers to 0 and busy_vec to 0. Reset asserted mid-operation discards any pending writes and allocs in that cycle. Outputs are combinational from cleared state, so rd_data = 0 and rd_busy = 0 while in reset.
- Write: at posedge clk, each port p with wr_en[p] = 1 writes wr_data[p] to regs[wr_addr[p]].
- Write conflicts: if two or more enabled ports target the same address, the highest-index port wins. Other registers are unchanged.
- Register 0: if ZERO_REG = 1, writes to address 0 are ignored, reads of address 0 return 0, and alloc to address 0 is ignored. busy_vec[0] is always 0.
- Invalid addresses: an address >= NREGS (possible when NREGS is not a power of 2) is ignored on writes and allocs. Reads of such an address return 0 and rd_busy = 0.
- Read: rd_data[i] = regs[rd_addr[i]], combinational, with zero latency.
- Bypass (BYPASS = 1): if any enabled write port in the current cycle matches rd_addr[i] (and the address is valid and not register 0), rd_data[i] = wr_data of the highest-index matching port. This gives write-then-read in the same cycle with 0-cycle visibility.
- No bypass (BYPASS = 0): a read sees the new value only from the cycle after the write.
- Scoreboard update at posedge clk:
  - busy[alloc_addr] is set when alloc_en = 1.
  - busy[wr_addr[p]] is cleared for every enabled write port.
  - If alloc and writeback hit the same register in the same cycle, the alloc wins: busy ends at 1, because a new producer now owns the register.
  - Alloc to a register that is already busy: busy stays 1 (no counting; one in-flight producer per register is the contract).
  - Writeback to a register that is not busy: data is written and busy stays 0.
- rd_busy[i]:
  - BYPASS = 1: rd_busy[i] = busy[rd_addr[i]] AND NOT (a same-cycle enabled write to rd_addr[i]).
  - BYPASS = 0: rd_busy[i] = busy[rd_addr[i]].
  - The same-cycle alloc is not reflected in rd_busy until the next cycle.
- busy_vec: a direct register output, updated only at posedge clk.
- Read ports are independent: identical addresses on several ports return identical data.

Test Plan:
1. Reset, then read all 32 addresses on both ports -> every rd_data = 0x00000000 and busy_vec = 0. Assert rst_h mid-stream after writing x5 = 0xDEADBEEF -> x5 reads 0 immediately.
2. wr_en = 2'b01, wr_addr0 = 7, wr_data0 = 0x12345678; at the same time, rd_addr0 = 7 -> rd_data0 = 0x12345678 in the same cycle when BYPASS = 1. With BYPASS = 0, it reads the old value 0 and then 0x12345678 on the next cycle.
3. Both write ports target x9 (port0 = 0xAAAA0000, port1 = 0x0000BBBB) -> x9 = 0x0000BBBB. Write 0xFFFFFFFF to x0 -> x0 still reads 0.
4. alloc_en with alloc_addr = 3 -> busy_vec[3] = 1 after the edge and rd_busy = 1 for reads of x3. Then port0 writes x3 = 0x55 -> rd_busy for x3 = 0 in that same cycle (bypass), and busy_vec[3] = 0 after the edge.
5. In one cycle, alloc x4 and write back x4 = 0x77 -> after the edge, x4 = 0x77 and busy_vec[4] = 1. alloc_en with alloc_addr = 0 -> busy_vec[0] stays 0.
6. Configuration NREGS = 24, NRD = 3, NWR = 3: write x25 = 0x1 -> no state change, and a read of x25 returns 0. A port-2 write to x23 beats port-0 and port-1 writes to x23. Three simultaneous reads of x23 all return the port-2 data.
